// File: rtl/tmds_decoder_if.sv
// Parallel TMDS lane bundle between the deserializer side and the decoder.
// The master drives the raw 10-bit word; the decoder (slave) returns pixel, control and lock status.
interface tmds_decoder_if;
  logic [9:0]  i_tmds;
  logic [7:0]  o_data;
  logic [1:0]  o_ctrl;
  logic        o_display_enable;
  logic        o_locked;
  logic [3:0]  o_offset;
  logic [15:0] o_err_count;

  modport master (
    output i_tmds,
    input  o_data, o_ctrl, o_display_enable,
    input  o_locked, o_offset, o_err_count
  );

  modport slave (
    input  i_tmds,
    output o_data, o_ctrl, o_display_enable,
    output o_locked, o_offset, o_err_count
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS lane decoder: word alignment by control-token lock, 2-stage decode, blanking.
// Define TMDS_DECODER_ERRCNT_EN to add the re-encode mismatch counter.
module tmds_decoder #(
  parameter int LOCK_COUNT = 16,
  parameter int MAX_GAP    = 8192
) (
  input logic           i_hdmi_clk,
  input logic           i_reset,
  tmds_decoder_if.slave bus
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int GW = $clog2(MAX_GAP + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] run, run_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [3:0]    offset, off_nx;
  logic [9:0]    prev, w, w_q;
  logic          pv, wv, adv;
  logic          tok;
  logic [1:0]    tok_c;
  logic [7:0]    x, d;
  logic [7:0]    data_q;
  logic [1:0]    ctrl_q;
  logic          de_q;

  assign w = 10'({bus.i_tmds, prev} >> offset);

  always_comb begin
    tok   = 1'b1;
    tok_c = 2'b00;
    unique case (1'b1)
      (w_q == 10'h354): tok_c = 2'b00;
      (w_q == 10'h0AB): tok_c = 2'b01;
      (w_q == 10'h154): tok_c = 2'b10;
      (w_q == 10'h2AB): tok_c = 2'b11;
      default:          tok   = 1'b0;
    endcase
  end

  always_comb begin
    x    = w_q[9] ? ~w_q[7:0] : w_q[7:0];
    d    = 8'h00;
    d[0] = x[0];
    for (int i = 1; i < 8; i++)
      d[i] = w_q[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
  end

  // wv drops for one word after an offset step: w_q then holds a stale-offset word
  always_comb begin
    state_nx = state;
    run_nx   = run;
    gap_nx   = gap;
    off_nx   = offset;
    adv      = 1'b0;
    if (wv) begin
      unique case (state)
        SEARCH: begin
          if (tok) begin
            run_nx = run + 1'b1;
            if (run == RW'(LOCK_COUNT - 1)) begin
              state_nx = LOCKED;
              gap_nx   = '0;
            end
          end else begin
            run_nx = '0;
            adv    = 1'b1;
            off_nx = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          end
        end
        LOCKED: begin
          if (tok) begin
            gap_nx = '0;
          end else begin
            gap_nx = gap + 1'b1;
            if (gap == GW'(MAX_GAP - 1)) begin
              state_nx = SEARCH;
              run_nx   = '0;
            end
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_hdmi_clk) begin
    if (i_reset) begin
      state  <= SEARCH;
      run    <= '0;
      gap    <= '0;
      offset <= '0;
      prev   <= '0;
      w_q    <= '0;
      pv     <= 1'b0;
      wv     <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
      de_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      run    <= run_nx;
      gap    <= gap_nx;
      offset <= off_nx;
      prev   <= bus.i_tmds;
      w_q    <= w;
      pv     <= 1'b1;
      wv     <= pv & ~adv;
      if (state != LOCKED) begin
        data_q <= '0;
        ctrl_q <= '0;
        de_q   <= 1'b0;
      end else if (tok) begin
        data_q <= '0;
        ctrl_q <= tok_c;
        de_q   <= 1'b0;
      end else begin
        data_q <= d;
        de_q   <= 1'b1;
      end
    end
  end

  assign bus.o_data           = data_q;
  assign bus.o_ctrl           = ctrl_q;
  assign bus.o_display_enable = de_q;
  assign bus.o_locked         = (state == LOCKED);
  assign bus.o_offset         = offset;

`ifdef TMDS_DECODER_ERRCNT_EN
  logic signed [5:0] bias, bias_nx, diff, qm2;
  logic [3:0]        n1d, n1q;
  logic [7:0]        q;
  logic              xn, q8;
  logic [9:0]        enc;
  logic [15:0]       err;

  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++)
      n1d = n1d + 4'(d[i]);
    xn   = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q8   = ~xn;
    q    = 8'h00;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    n1q = 4'd0;
    for (int i = 0; i < 8; i++)
      n1q = n1q + 4'(q[i]);
    diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    qm2  = q8 ? 6'sd2 : 6'sd0;
    if ((bias == 6'sd0) || (n1q == 4'd4)) begin
      enc     = {~q8, q8, q8 ? q : ~q};
      bias_nx = q8 ? bias + diff : bias - diff;
    end else if ((!bias[5] && (n1q > 4'd4)) || (bias[5] && (n1q < 4'd4))) begin
      enc     = {1'b1, q8, ~q};
      bias_nx = bias + qm2 - diff;
    end else begin
      enc     = {1'b0, q8, q};
      bias_nx = bias - (6'sd2 - qm2) + diff;
    end
  end

  always_ff @(posedge i_hdmi_clk) begin
    if (i_reset) begin
      bias <= '0;
      err  <= '0;
    end else if (wv) begin
      if (tok) begin
        bias <= '0;
      end else if (state == LOCKED) begin
        bias <= bias_nx;
        if ((enc != w_q) && (err != 16'hFFFF))
          err <= err + 16'd1;
      end
    end
  end

  assign bus.o_err_count = err;
`else
  assign bus.o_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, lock at offsets 0 and 3, decode,
// control tokens, gap timeout and the optional re-encode error counter.
module tb_tmds_decoder;

  localparam logic [9:0] TOK = 10'h354;
`ifdef TMDS_DECODER_ERRCNT_EN
  localparam logic [15:0] ERR1 = 16'd1;
`else
  localparam logic [15:0] ERR1 = 16'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dly = 1'b0;
  logic [9:0] last = '0;
  int         nvec = 0;
  int         nbad = 0;

  always #5 clk = ~clk;

  tmds_decoder_if bus ();

  tmds_decoder #(
    .LOCK_COUNT (16),
    .MAX_GAP    (64)
  ) dut (
    .i_hdmi_clk (clk),
    .i_reset    (rst),
    .bus        (bus.slave)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // dly=1 shifts the serial stream 3 bits later
  task automatic send(input logic [9:0] sym);
    if (dly)
      bus.i_tmds = {sym[6:0], last[9:7]};
    else
      bus.i_tmds = sym;
    last = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic data_chk(input logic [9:0] sym, input logic [7:0] exp);
    send(sym);
    send(TOK);
    send(TOK);
    chk("data", 16'(bus.o_data), 16'(exp));
    chk("data_de", 16'(bus.o_display_enable), 16'd1);
  endtask

  task automatic ctrl_chk(input logic [9:0] sym, input logic [1:0] exp);
    repeat (3) send(sym);
    chk("ctrl", 16'(bus.o_ctrl), 16'(exp));
    chk("ctrl_de", 16'(bus.o_display_enable), 16'd0);
    chk("ctrl_data", 16'(bus.o_data), 16'd0);
  endtask

  initial begin
    bus.i_tmds = '0;
    rst = 1'b1;
    repeat (3) send(10'($urandom));
    chk("rst_data", 16'(bus.o_data), 16'd0);
    chk("rst_ctrl", 16'(bus.o_ctrl), 16'd0);
    chk("rst_de", 16'(bus.o_display_enable), 16'd0);
    chk("rst_locked", 16'(bus.o_locked), 16'd0);
    chk("rst_offset", 16'(bus.o_offset), 16'd0);
    chk("rst_err", bus.o_err_count, 16'd0);
    rst = 1'b0;

    repeat (16) send(TOK);
    send(10'h100);
    chk("lock_early", 16'(bus.o_locked), 16'd0);
    send(TOK);
    chk("lock_rise", 16'(bus.o_locked), 16'd1);
    chk("blank_before", 16'(bus.o_display_enable), 16'd0);
    send(TOK);
    chk("first_data", 16'(bus.o_data), 16'h00);
    chk("first_de", 16'(bus.o_display_enable), 16'd1);
    chk("offset0", 16'(bus.o_offset), 16'd0);

    data_chk(10'h1FF, 8'h01);
    data_chk(10'h2FF, 8'hFE);
    data_chk(10'h20F, 8'hEE);

    ctrl_chk(10'h0AB, 2'b01);
    ctrl_chk(10'h154, 2'b10);
    ctrl_chk(10'h2AB, 2'b11);
    data_chk(10'h100, 8'h00);
    chk("ctrl_hold", 16'(bus.o_ctrl), 16'd3);

    chk("err_clean", bus.o_err_count, 16'd0);
    data_chk(10'h300, 8'h01);
    chk("err_flip", bus.o_err_count, ERR1);

    repeat (64) send(10'h100);
    send(TOK);
    chk("gap_still", 16'(bus.o_locked), 16'd1);
    send(TOK);
    chk("gap_drop", 16'(bus.o_locked), 16'd0);
    chk("gap_last_de", 16'(bus.o_display_enable), 16'd1);
    send(TOK);
    chk("gap_blank", 16'(bus.o_display_enable), 16'd0);
    chk("gap_blank_d", 16'(bus.o_data), 16'd0);

    rst = 1'b1;
    send(TOK);
    send(TOK);
    chk("rst2_offset", 16'(bus.o_offset), 16'd0);
    rst = 1'b0;
    dly = 1'b1;
    last = '0;
    repeat (30) send(TOK);
    chk("dly_locked", 16'(bus.o_locked), 16'd1);
    chk("dly_offset", 16'(bus.o_offset), 16'd3);
    data_chk(10'h100, 8'h00);
    data_chk(10'h2FF, 8'hFE);
    ctrl_chk(10'h0AB, 2'b01);

    rst = 1'b1;
    send(TOK);
    chk("mid_locked", 16'(bus.o_locked), 16'd0);
    chk("mid_offset", 16'(bus.o_offset), 16'd0);
    chk("mid_de", 16'(bus.o_display_enable), 16'd0);
    chk("mid_err", bus.o_err_count, 16'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
